// File: rtl/clock_ratio_meter_pkg.sv
// Shared definitions for the clock ratio meter and the PWM divider blocks it checks.
package clock_ratio_meter_pkg;

   localparam int CRM_WIDTH = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARM     = 2'd1,
      ST_MEASURE = 2'd2
   } crm_state_e;

endpackage

// File: rtl/clock_ratio_meter_sig_sync.sv
// Multi-stage synchronizer for an asynchronous clock-like input plus rising-edge detect.
module sig_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_sig,
   output logic o_s,
   output logic o_rise
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   s_d_q, s_d_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], i_sig};
      s_d_d  = sync_q[SYNC_STAGES-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         s_d_q  <= 1'b0;
      end else begin
         sync_q <= sync_d;
         s_d_q  <= s_d_d;
      end
   end

   assign o_s    = sync_q[SYNC_STAGES-1];
   assign o_rise = o_s & ~s_d_q;

endmodule

// File: rtl/clock_ratio_meter.sv
// Measures period and high time of a divided clock in system-clock cycles, with lock and timeout flags.
module clock_ratio_meter
   import clock_ratio_meter_pkg::*;
#(
   parameter int WIDTH       = CRM_WIDTH,
   parameter int SYNC_STAGES = 2,
   parameter int LOCK_COUNT  = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic             i_sig,
   output logic [WIDTH-1:0] o_period,
   output logic [WIDTH-1:0] o_high,
   output logic             o_valid,
   output logic             o_locked,
   output logic             o_timeout
);

   localparam int             MW        = $clog2(LOCK_COUNT);
   localparam logic [MW-1:0]  MATCH_MAX = MW'(LOCK_COUNT - 1);
   localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   logic s, rise;

   sig_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk    (i_clk),
      .rst_n  (i_rst_n),
      .i_sig  (i_sig),
      .o_s    (s),
      .o_rise (rise)
   );

   crm_state_e       state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] hcnt_q, hcnt_d;
   logic [WIDTH-1:0] period_q, period_d;
   logic [WIDTH-1:0] high_q, high_d;
   logic             valid_q, valid_d;
   logic             locked_q, locked_d;
   logic             timeout_q, timeout_d;
   logic [MW-1:0]    match_q, match_d;
   logic [MW-1:0]    match_nxt;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hcnt_d    = hcnt_q;
      period_d  = period_q;
      high_d    = high_q;
      valid_d   = 1'b0;
      locked_d  = locked_q;
      timeout_d = timeout_q;
      match_d   = match_q;
      match_nxt = '0;

      // Disable wins over everything, including a rise in the same cycle.
      if (!i_en) begin
         state_d  = ST_IDLE;
         cnt_d    = '0;
         hcnt_d   = '0;
         locked_d = 1'b0;
         match_d  = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               cnt_d   = '0;
               hcnt_d  = '0;
               state_d = ST_ARM;
            end
            ST_ARM: begin
               if (rise) begin
                  cnt_d   = ONE;
                  hcnt_d  = ONE;
                  state_d = ST_MEASURE;
               end
            end
            ST_MEASURE: begin
               if (rise) begin
                  period_d  = cnt_q;
                  high_d    = hcnt_q;
                  valid_d   = 1'b1;
                  timeout_d = 1'b0;
                  cnt_d     = ONE;
                  hcnt_d    = ONE;
                  if (cnt_q == period_q)
                     match_nxt = (match_q == MATCH_MAX) ? match_q : match_q + MW'(1);
                  else
                     match_nxt = '0;
                  match_d  = match_nxt;
                  locked_d = (match_nxt == MATCH_MAX);
               end else if (cnt_q == CNT_MAX) begin
                  timeout_d = 1'b1;
                  locked_d  = 1'b0;
                  match_d   = '0;
                  state_d   = ST_ARM;
               end else begin
                  cnt_d  = cnt_q + ONE;
                  hcnt_d = hcnt_q + {{(WIDTH-1){1'b0}}, s};
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         hcnt_q    <= '0;
         period_q  <= '0;
         high_q    <= '0;
         valid_q   <= 1'b0;
         locked_q  <= 1'b0;
         timeout_q <= 1'b0;
         match_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hcnt_q    <= hcnt_d;
         period_q  <= period_d;
         high_q    <= high_d;
         valid_q   <= valid_d;
         locked_q  <= locked_d;
         timeout_q <= timeout_d;
         match_q   <= match_d;
      end
   end

   assign o_period  = period_q;
   assign o_high    = high_q;
   assign o_valid   = valid_q;
   assign o_locked  = locked_q;
   assign o_timeout = timeout_q;

endmodule
